// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Purpose  : Shared widths, funct3 load/store encodings, sequencer state enum
//            and lane helpers for the memory writeback unit.
// Revision : 1.0
// ============================================================================
package core_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam int TMO_W = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WB   = 2'd2,
        S_FIN  = 2'd3
    } state_e;

    // Loads reject 011/11x; stores reject anything above SW.
    function automatic logic f3_illegal(input logic is_load, input logic [2:0] f3);
        if (is_load) begin
            return (f3 == 3'b011) || (f3[2:1] == 2'b11);
        end
        return f3 > F3_W;
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] access_be(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] lane_replicate(input logic [1:0] sz,
                                                       input logic [XLEN-1:0] d);
        case (sz)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_aligner.sv
`default_nettype none
// ============================================================================
// Module   : load_aligner
// Purpose  : Combinational lane select plus sign/zero extension of a read word.
// Revision : 1.0
// ============================================================================
module load_aligner
    import core_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (addr_lo_i)
            2'b00:   w_byte = rdata_i[7:0];
            2'b01:   w_byte = rdata_i[15:8];
            2'b10:   w_byte = rdata_i[23:16];
            default: w_byte = rdata_i[31:24];
        endcase
    end

    // Halfword lane ignores addr[0] so a misaligned LH truncates to its half.
    assign w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        case (funct3_i)
            F3_B:    data_o = {{24{w_byte[7]}}, w_byte};
            F3_H:    data_o = {{16{w_half[15]}}, w_half};
            F3_BU:   data_o = {24'd0, w_byte};
            F3_HU:   data_o = {16'd0, w_half};
            default: data_o = rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_writeback_unit
// Purpose  : Load/store sequencer between execute and data memory with
//            register-bank writeback. Option macro: MISALIGN_TRAP_EN.
// Revision : 1.0
// ============================================================================
module mem_writeback_unit
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             stage_clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_load,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  addr,
    input  logic [XLEN-1:0]  store_data,
    input  logic [REG_W-1:0] rd,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_ack,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic [REG_W-1:0] wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic             save_from_memory
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    state_e             state_q;
    logic               is_load_q;
    logic [2:0]         funct3_q;
    logic [1:0]         addr_lo_q;
    logic [REG_W-1:0]   rd_q;
    logic [TMO_W-1:0]   cnt_q;
    logic [TMO_W-1:0]   cnt_d;
    logic               done_q;
    logic               err_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [XLEN-1:0]    mem_addr_q;
    logic [XLEN-1:0]    mem_wdata_q;
    logic [3:0]         mem_be_q;
    logic [REG_W-1:0]   wb_rd_q;
    logic [XLEN-1:0]    wb_data_q;
    logic               save_q;

    logic [XLEN-1:0]    w_ext;
    logic               w_abort;

    load_aligner u_load_aligner (
        .rdata_i   (mem_rdata),
        .addr_lo_i (addr_lo_q),
        .funct3_i  (funct3_q),
        .data_o    (w_ext)
    );

`ifdef MISALIGN_TRAP_EN
    assign w_abort = f3_illegal(is_load, funct3) || misaligned(funct3[1:0], addr[1:0]);
`else
    assign w_abort = f3_illegal(is_load, funct3);
`endif

    assign cnt_d = cnt_q + TMO_W'(1);

    always_ff @(posedge stage_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            is_load_q   <= 1'b0;
            funct3_q    <= 3'd0;
            addr_lo_q   <= 2'd0;
            rd_q        <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'd0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            save_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            save_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        is_load_q <= is_load;
                        funct3_q  <= funct3;
                        addr_lo_q <= addr[1:0];
                        rd_q      <= rd;
                        cnt_q     <= '0;
                        if (w_abort) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q     <= S_REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= !is_load;
                            mem_addr_q  <= {addr[XLEN-1:2], 2'b00};
                            mem_be_q    <= access_be(funct3[1:0], addr[1:0]);
                            mem_wdata_q <= is_load ? '0 : lane_replicate(funct3[1:0], store_data);
                        end
                    end
                end
                S_REQ: begin
                    // mem_req drops one cycle before the abort so FIN lands at T+2.
                    if (cnt_q == TMO_LIMIT) begin
                        state_q     <= S_FIN;
                        done_q      <= 1'b1;
                        err_q       <= 1'b1;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        mem_be_q    <= 4'd0;
                    end else if (mem_ack) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        mem_be_q    <= 4'd0;
                        if (is_load_q) begin
                            state_q   <= S_WB;
                            wb_rd_q   <= rd_q;
                            wb_data_q <= w_ext;
                            save_q    <= (rd_q != '0);
                        end else begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == TMO_LIMIT) begin
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                S_WB: begin
                    state_q <= S_FIN;
                    done_q  <= 1'b1;
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;
    assign err              = err_q;
    assign mem_req          = mem_req_q;
    assign mem_we           = mem_we_q;
    assign mem_addr         = mem_addr_q;
    assign mem_wdata        = mem_wdata_q;
    assign mem_be           = mem_be_q;
    assign wb_rd            = wb_rd_q;
    assign wb_data          = wb_data_q;
    assign save_from_memory = save_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_writeback_unit
// Purpose  : Scoreboard bench for mem_writeback_unit (TIMEOUT_CYCLES = 4).
// Revision : 1.0
// ============================================================================
module tb_mem_writeback_unit;

    localparam int TMO = 4;

    logic        stage_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        save_from_memory;

    int total = 0;
    int bad = 0;
    logic [36:0] wbq[$];

    always #5 stage_clk = ~stage_clk;

    mem_writeback_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .stage_clk        (stage_clk),
        .reset_n          (reset_n),
        .start            (start),
        .is_load          (is_load),
        .funct3           (funct3),
        .addr             (addr),
        .store_data       (store_data),
        .rd               (rd),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_be           (mem_be),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .wb_rd            (wb_rd),
        .wb_data          (wb_data),
        .save_from_memory (save_from_memory)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [1:0] lo,
                                            input logic [2:0] f3);
        int          bits;
        int          sh;
        logic [31:0] s;
        logic [31:0] mask;
        bits = (f3[1:0] == 2'b00) ? 8 : (f3[1:0] == 2'b01) ? 16 : 32;
        sh   = (bits == 8) ? 8 * int'(lo) : (bits == 16) ? 16 * int'(lo[1]) : 0;
        s    = w >> sh;
        if (bits == 32) return s;
        mask = (32'h1 << bits) - 32'h1;
        s    = s & mask;
        if (!f3[2] && s[bits-1]) s = s | ~mask;
        return s;
    endfunction

    // Runs one operation; ack_cyc = 0 means memory never acknowledges.
    task automatic run_op(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [4:0] rdst, input logic [31:0] rdata,
                          input int ack_cyc, input bit noise, input bit exp_req,
                          input int exp_be, input longint exp_wdata, input logic [31:0] exp_wb);
        int          first_req, last_req, done_cyc, save_n, exp_done, exp_last;
        bit          exp_err, exp_save;
        logic [36:0] item;
        first_req = -1; last_req = -1; done_cyc = -1; save_n = 0;
        exp_err  = !exp_req || (ack_cyc == 0);
        exp_save = exp_req && ld && (ack_cyc != 0) && (rdst != 5'd0);
        if (!exp_req)          exp_done = 1;
        else if (ack_cyc == 0) exp_done = TMO + 2;
        else                   exp_done = ld ? ack_cyc + 2 : ack_cyc + 1;
        exp_last = !exp_req ? -1 : ((ack_cyc == 0) ? TMO : ack_cyc);
        if (exp_save) wbq.push_back({rdst, exp_wb});

        @(posedge stage_clk); #1;
        start = 1'b1; is_load = ld; funct3 = f3; addr = a; store_data = sd; rd = rdst;
        mem_rdata = rdata;
        for (int c = 0; c < 40 && done_cyc < 0; c++) begin
            if (c == 1) begin
                if (noise) funct3 = 3'b111;
                else       start = 1'b0;
            end
            if (c == 3) start = 1'b0;
            mem_ack = (ack_cyc != 0) && ((c == ack_cyc) || (noise && c == ack_cyc + 1));
            @(negedge stage_clk);
            if (mem_req) begin
                if (first_req < 0) begin
                    first_req = c;
                    check_eq("mem_addr", mem_addr, {a[31:2], 2'b00});
                    check_eq("mem_we", {31'd0, mem_we}, {31'd0, !ld});
                    if (exp_be >= 0) check_eq("mem_be", {28'd0, mem_be}, exp_be);
                    if (exp_wdata >= 0) check_eq("mem_wdata", mem_wdata, exp_wdata[31:0]);
                end
                last_req = c;
            end
            if (save_from_memory) begin
                save_n++;
                check_eq("save_cycle", c, ack_cyc + 1);
                if (wbq.size() != 0) begin
                    item = wbq.pop_front();
                    check_eq("wb_rd", {27'd0, wb_rd}, {27'd0, item[36:32]});
                    check_eq("wb_data", wb_data, item[31:0]);
                end
            end
            check_eq("err_pulse", {31'd0, err}, {31'd0, done & exp_err});
            if (done) done_cyc = c;
            @(posedge stage_clk); #1;
        end
        start = 1'b0; mem_ack = 1'b0;
        check_eq("done_cycle", done_cyc, exp_done);
        check_eq("first_req", first_req, exp_req ? 1 : -1);
        check_eq("last_req", last_req, exp_last);
        check_eq("save_count", save_n, exp_save ? 1 : 0);
        check_eq("wbq_empty", wbq.size(), 0);
    endtask

    initial begin
        logic [31:0] rw;
        logic [1:0]  lo;
        logic [2:0]  f3s [5];
        logic [2:0]  f3;
        bit          seen;
        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        repeat (3) @(posedge stage_clk);
        #1;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_save", {31'd0, save_from_memory}, 32'd0);
        check_eq("rst_wbdata", wb_data, 32'd0);
        check_eq("rst_be", {28'd0, mem_be}, 32'd0);
        reset_n = 1'b1;

        run_op(1, 3'b010, 32'h100, 0, 5'd5, 32'hDEADBEEF, 2, 0, 1, 15, -1, 32'hDEADBEEF);
        run_op(1, 3'b000, 32'h103, 0, 5'd6, 32'h80FFFFFF, 1, 0, 1, -1, -1, 32'hFFFFFF80);
        run_op(1, 3'b100, 32'h103, 0, 5'd7, 32'h80FFFFFF, 3, 1, 1, -1, -1, 32'h00000080);
        run_op(0, 3'b001, 32'h102, 32'h1234ABCD, 5'd9, 0, 2, 0, 1, 12, 32'hABCDABCD, 0);
        run_op(0, 3'b000, 32'h201, 32'hAA000055, 5'd0, 0, 1, 1, 1, 2, 32'h55555555, 0);
        run_op(0, 3'b010, 32'h300, 32'hCAFEF00D, 5'd1, 0, 4, 0, 1, 15, 32'hCAFEF00D, 0);
        run_op(1, 3'b010, 32'h104, 0, 5'd0, 32'h12345678, 1, 0, 1, 15, -1, 0);
        run_op(1, 3'b010, 32'h108, 0, 5'd3, 32'h0BADF00D, 0, 0, 1, 15, -1, 0);
        run_op(1, 3'b011, 32'h10C, 0, 5'd4, 0, 1, 0, 0, -1, -1, 0);
        run_op(0, 3'b100, 32'h10C, 32'h1, 5'd4, 0, 1, 0, 0, -1, -1, 0);
        run_op(1, 3'b001, 32'h102, 0, 5'd10, 32'h80011234, 2, 0, 1, -1, -1, 32'hFFFF8001);
        run_op(1, 3'b101, 32'h100, 0, 5'd11, 32'h8001F00F, 1, 0, 1, -1, -1, 32'h0000F00F);
`ifdef MISALIGN_TRAP_EN
        run_op(1, 3'b010, 32'h101, 0, 5'd8, 32'h11223344, 2, 0, 0, -1, -1, 0);
        run_op(1, 3'b001, 32'h103, 0, 5'd8, 32'h80011234, 1, 0, 0, -1, -1, 0);
`else
        run_op(1, 3'b010, 32'h101, 0, 5'd8, 32'h11223344, 2, 0, 1, 15, -1, 32'h11223344);
        run_op(1, 3'b001, 32'h103, 0, 5'd8, 32'h80011234, 1, 0, 1, -1, -1, 32'hFFFF8001);
`endif

        for (int i = 0; i < 6; i++) begin
            f3 = f3s[$urandom_range(0, 4)];
            rw = $urandom;
            lo = (f3[1:0] == 2'b00) ? 2'($urandom_range(0, 3)) :
                 (f3[1:0] == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
            run_op(1, f3, 32'h800 + 32'(i * 4) + {30'd0, lo}, 0, 5'($urandom_range(1, 31)),
                   rw, $urandom_range(1, 3), 0, 1, -1, -1, ref_ext(rw, lo, f3));
        end

        // Reset during REQ must drop the access with no writeback.
        @(posedge stage_clk); #1;
        start = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h400; rd = 5'd7;
        @(posedge stage_clk); #1;
        start = 1'b0;
        @(negedge stage_clk);
        check_eq("rst_mid_req_pre", {31'd0, mem_req}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_mid_addr", mem_addr, 32'd0);
        @(posedge stage_clk); #1;
        reset_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        seen = 1'b0;
        repeat (5) begin
            @(negedge stage_clk);
            seen = seen | save_from_memory | done | mem_req | busy;
        end
        mem_ack = 1'b0;
        check_eq("rst_mid_no_wb", {31'd0, seen}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
